vga_sync_rx: RTL and testbench

- Receiving end of the 480p pixel-stream interface: consumes hsync/vsync/de plus 8-bit RGB, as produced by the display timing generator and raymarcher path.
- Recovers pixel coordinates from the syncs alone and checks timing against the nominal 640x480 raster (800x525 total).
- Declares lock after consecutive clean frames and re-emits a qualified pixel stream for capture and checking in simulation and on hardware.

---
 rtl/vga_sync_rx.sv | 188 ++++++++++++++++++
 tb/tb_vga_sync_rx.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_rx.sv
// rtl/vga_sync_rx.sv - raster receiver: recovers pixel coordinates from syncs, checks timing, locks and re-emits pixels
module vga_sync_rx #(
  parameter int CORDW       = 10,
  parameter int H_ACTIVE    = 640,
  parameter int H_TOTAL     = 800,
  parameter int V_ACTIVE    = 480,
  parameter int V_TOTAL     = 525,
  parameter bit HSYNC_POL   = 1'b0,
  parameter bit VSYNC_POL   = 1'b0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic             clk_pix,
  input  logic             rst_pix,
  input  logic             hsync,
  input  logic             vsync,
  input  logic             de,
  input  logic [7:0]       r,
  input  logic [7:0]       g,
  input  logic [7:0]       b,
  output logic [CORDW-1:0] rx_x,
  output logic [CORDW-1:0] rx_y,
  output logic             rx_valid,
  output logic [7:0]       rx_r,
  output logic [7:0]       rx_g,
  output logic [7:0]       rx_b,
  output logic             frame_start,
  output logic             locked,
  output logic             lock_lost,
  output logic [3:0]       err_flags
);

  localparam logic [CORDW-1:0] CMAX = '1;
  localparam int GW = (LOCK_FRAMES > 1) ? $clog2(LOCK_FRAMES) : 1;

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  state_t           state_q, state_d;
  logic             hs_a_q, hs_a_d, vs_a_q, vs_a_d, de_q, de_d;
  logic [CORDW-1:0] h_len_q, h_len_d, px_cnt_q, px_cnt_d;
  logic [CORDW-1:0] v_len_q, v_len_d, act_ln_q, act_ln_d;
  logic [GW-1:0]    good_q, good_d;
  logic             bad_q, bad_d;
  logic [3:0]       err_flags_q, err_flags_d;
  logic             locked_q, locked_d, lock_lost_q, lock_lost_d;
  logic             rx_valid_q, rx_valid_d, frame_start_q, frame_start_d;
  logic [CORDW-1:0] rx_x_q, rx_x_d, rx_y_q, rx_y_d;
  logic [7:0]       rx_r_q, rx_r_d, rx_g_q, rx_g_d, rx_b_q, rx_b_d;

  logic             hs_a, vs_a, hs_rise, vs_rise, de_fall, err_any;
  logic [CORDW:0]   v_cnt, a_cnt;
  logic [3:0]       err_now;

  always_comb begin
    hs_a    = (hsync == HSYNC_POL);
    vs_a    = (vsync == VSYNC_POL);
    hs_rise = hs_a & ~hs_a_q;
    vs_rise = vs_a & ~vs_a_q;
    de_fall = ~de & de_q;
    hs_a_d  = hs_a;
    vs_a_d  = vs_a;
    de_d    = de;

    // Events coincident with vs_rise belong to the frame that is ending.
    v_cnt = {1'b0, v_len_q} + (CORDW+1)'(hs_rise);
    a_cnt = {1'b0, act_ln_q} + (CORDW+1)'(de_fall);

    // px_cnt already includes the last active pixel when de falls.
    err_now[0] = hs_rise && (h_len_q != CORDW'(H_TOTAL - 1));
    err_now[1] = de_fall && (px_cnt_q != CORDW'(H_ACTIVE));
    err_now[2] = vs_rise && (v_cnt != (CORDW+1)'(V_TOTAL));
    err_now[3] = vs_rise && (a_cnt != (CORDW+1)'(V_ACTIVE));
    err_any    = |err_now;

    h_len_d  = hs_rise ? '0 : ((h_len_q == CMAX) ? h_len_q : h_len_q + 1'b1);
    px_cnt_d = de_fall ? '0 : ((de && px_cnt_q != CMAX) ? px_cnt_q + 1'b1 : px_cnt_q);
    v_len_d  = vs_rise ? '0 : ((hs_rise && v_len_q != CMAX) ? v_len_q + 1'b1 : v_len_q);
    act_ln_d = vs_rise ? '0 : ((de_fall && act_ln_q != CMAX) ? act_ln_q + 1'b1 : act_ln_q);

    err_flags_d = err_flags_q | ((state_q != SEARCH) ? err_now : 4'b0000);

    state_d = state_q;
    good_d  = good_q;
    bad_d   = bad_q;
    case (state_q)
      SEARCH: begin
        if (vs_rise) begin
          state_d = ACQUIRE;
          good_d  = '0;
          bad_d   = 1'b0;
        end
      end
      ACQUIRE: begin
        bad_d = bad_q | err_any;
        if (vs_rise) begin
          bad_d = 1'b0;
          if (bad_q || err_any) begin
            good_d = '0;
          end else if (good_q == GW'(LOCK_FRAMES - 1)) begin
            state_d = LOCKED;
            good_d  = '0;
          end else begin
            good_d = good_q + 1'b1;
          end
        end
      end
      LOCKED: begin
        if (err_any) state_d = SEARCH;
      end
      default: state_d = SEARCH;
    endcase

    lock_lost_d = (state_q == LOCKED) && err_any;
    locked_d    = (state_d == LOCKED);

    rx_valid_d    = locked_q & de;
    frame_start_d = locked_q & de & (px_cnt_q == '0) & (act_ln_q == '0);
    rx_x_d = '0;
    rx_y_d = '0;
    rx_r_d = 8'h00;
    rx_g_d = 8'h00;
    rx_b_d = 8'h00;
    if (rx_valid_d) begin
      rx_x_d = px_cnt_q;
      rx_y_d = act_ln_q;
      rx_r_d = r;
      rx_g_d = g;
      rx_b_d = b;
    end
  end

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      state_q       <= SEARCH;
      hs_a_q        <= 1'b0;
      vs_a_q        <= 1'b0;
      de_q          <= 1'b0;
      h_len_q       <= '0;
      px_cnt_q      <= '0;
      v_len_q       <= '0;
      act_ln_q      <= '0;
      good_q        <= '0;
      bad_q         <= 1'b0;
      err_flags_q   <= 4'b0000;
      locked_q      <= 1'b0;
      lock_lost_q   <= 1'b0;
      rx_valid_q    <= 1'b0;
      frame_start_q <= 1'b0;
      rx_x_q        <= '0;
      rx_y_q        <= '0;
      rx_r_q        <= 8'h00;
      rx_g_q        <= 8'h00;
      rx_b_q        <= 8'h00;
    end else begin
      state_q       <= state_d;
      hs_a_q        <= hs_a_d;
      vs_a_q        <= vs_a_d;
      de_q          <= de_d;
      h_len_q       <= h_len_d;
      px_cnt_q      <= px_cnt_d;
      v_len_q       <= v_len_d;
      act_ln_q      <= act_ln_d;
      good_q        <= good_d;
      bad_q         <= bad_d;
      err_flags_q   <= err_flags_d;
      locked_q      <= locked_d;
      lock_lost_q   <= lock_lost_d;
      rx_valid_q    <= rx_valid_d;
      frame_start_q <= frame_start_d;
      rx_x_q        <= rx_x_d;
      rx_y_q        <= rx_y_d;
      rx_r_q        <= rx_r_d;
      rx_g_q        <= rx_g_d;
      rx_b_q        <= rx_b_d;
    end
  end

  assign rx_x        = rx_x_q;
  assign rx_y        = rx_y_q;
  assign rx_valid    = rx_valid_q;
  assign rx_r        = rx_r_q;
  assign rx_g        = rx_g_q;
  assign rx_b        = rx_b_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;
  assign lock_lost   = lock_lost_q;
  assign err_flags   = err_flags_q;

endmodule

// File: tb/tb_vga_sync_rx.sv
// tb/tb_vga_sync_rx.sv - scoreboard bench for vga_sync_rx on a reduced 32x24 (40x30 total) raster
`timescale 1ns/1ps
module tb_vga_sync_rx;

  localparam int CORDW    = 10;
  localparam int H_ACTIVE = 32;
  localparam int H_TOTAL  = 40;
  localparam int V_ACTIVE = 24;
  localparam int V_TOTAL  = 30;
  localparam int HS_BEG   = 34;
  localparam int HS_END   = 38;
  localparam int VS_LINE  = 26;

  logic             clk_pix = 1'b0;
  logic             rst_pix;
  logic             hsync, vsync, de;
  logic [7:0]       r, g, b;
  logic [CORDW-1:0] rx_x, rx_y;
  logic             rx_valid;
  logic [7:0]       rx_r, rx_g, rx_b;
  logic             frame_start, locked, lock_lost;
  logic [3:0]       err_flags;

  vga_sync_rx #(
    .CORDW(CORDW), .H_ACTIVE(H_ACTIVE), .H_TOTAL(H_TOTAL),
    .V_ACTIVE(V_ACTIVE), .V_TOTAL(V_TOTAL),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .LOCK_FRAMES(2)
  ) dut (
    .clk_pix(clk_pix), .rst_pix(rst_pix),
    .hsync(hsync), .vsync(vsync), .de(de),
    .r(r), .g(g), .b(b),
    .rx_x(rx_x), .rx_y(rx_y), .rx_valid(rx_valid),
    .rx_r(rx_r), .rx_g(rx_g), .rx_b(rx_b),
    .frame_start(frame_start), .locked(locked), .lock_lost(lock_lost),
    .err_flags(err_flags)
  );

  always #5 clk_pix = ~clk_pix;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       fs;
  } px_t;

  px_t  exp_q[$];
  px_t  mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic exp_lock = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk_pix) begin
    if (rx_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 64'(rx_valid), 64'(0));
      end else begin
        mon_e = exp_q.pop_front();
        check("pixel", 64'({rx_x, rx_y, rx_r, rx_g, rx_b, frame_start}), 64'(mon_e));
      end
    end else begin
      check("idle_zero", 64'({rx_valid, rx_x, rx_y, rx_r, rx_g, rx_b, frame_start}), 64'(0));
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_rx_x"},     64'(rx_x), 64'(0));
    check({tag, "_rx_y"},     64'(rx_y), 64'(0));
    check({tag, "_rx_valid"}, 64'(rx_valid), 64'(0));
    check({tag, "_rgb"},      64'({rx_r, rx_g, rx_b}), 64'(0));
    check({tag, "_fs"},       64'(frame_start), 64'(0));
    check({tag, "_locked"},   64'(locked), 64'(0));
    check({tag, "_lost"},     64'(lock_lost), 64'(0));
    check({tag, "_err"},      64'(err_flags), 64'(0));
  endtask

  task automatic drive_frame(input int n_lines, input int n_act, input int short_ln,
                             input int long_ln, input int rst_ln, input logic lk_before,
                             input logic lk_after, input logic [3:0] exp_err);
    int len, act_w;
    for (int y = 0; y < n_lines; y++) begin
      len   = (y == short_ln) ? H_TOTAL - 1 : H_TOTAL;
      act_w = (y == long_ln) ? H_ACTIVE + 1 : H_ACTIVE;
      for (int sx = 0; sx < len; sx++) begin
        hsync = !(sx >= HS_BEG && sx < HS_END);
        vsync = !(y == VS_LINE || y == VS_LINE + 1);
        de    = (y < n_act) && (sx < act_w);
        r     = (sx == 10 && y == 20) ? 8'h12 : 8'(sx * 5 + y);
        g     = 8'(y * 9 + 1);
        b     = 8'(sx ^ y ^ 165);
        if (de && exp_lock)
          exp_q.push_back({10'(sx), 10'(y), r, g, b, (sx == 0 && y == 0)});
        if (y == rst_ln && sx == 6) begin
          check("pre_rst_valid", 64'(rx_valid), 64'(1));
          #1 rst_pix = 1'b1;
          hsync = 1'b1; vsync = 1'b1; de = 1'b0;
          #1 check_all_zero("async_rst");
          exp_q.delete();
          exp_lock = 1'b0;
          repeat (2) @(posedge clk_pix);
          @(negedge clk_pix);
          rst_pix = 1'b0;
          return;
        end
        if (y == VS_LINE && sx == 0) check("lock_pre", 64'(locked), 64'(lk_before));
        @(posedge clk_pix);
        #1;
        if (y == VS_LINE && sx == 0) begin
          check("lock_post",   64'(locked), 64'(lk_after));
          check("lost_at_vs",  64'(lock_lost), 64'(lk_before & ~lk_after));
          check("err_flags",   64'(err_flags), 64'(exp_err));
          check("sb_drained",  64'(exp_q.size()), 64'(0));
          exp_lock = lk_after;
        end
        if (short_ln >= 0 && y == short_ln + 1 && sx == HS_BEG) begin
          check("lost_pulse", 64'(lock_lost), 64'(1));
          check("lock_drop",  64'(locked), 64'(0));
          check("err_short",  64'(err_flags), 64'(exp_err));
          exp_lock = 1'b0;
        end
        if (short_ln >= 0 && y == short_ln + 1 && sx == HS_BEG + 1)
          check("lost_once", 64'(lock_lost), 64'(0));
      end
    end
  endtask

  initial begin
    rst_pix = 1'b1;
    hsync = 1'b1; vsync = 1'b1; de = 1'b0;
    r = 8'h00; g = 8'h00; b = 8'h00;
    repeat (3) @(posedge clk_pix);
    #1 check_all_zero("reset");
    @(negedge clk_pix);
    rst_pix = 1'b0;

    // Lock on the third vs_rise, then one fully locked frame of pixels.
    drive_frame(V_TOTAL, V_ACTIVE, -1, -1, -1, 1'b0, 1'b0, 4'h0);
    drive_frame(V_TOTAL, V_ACTIVE, -1, -1, -1, 1'b0, 1'b0, 4'h0);
    drive_frame(V_TOTAL, V_ACTIVE, -1, -1, -1, 1'b0, 1'b1, 4'h0);
    drive_frame(V_TOTAL, V_ACTIVE, -1, -1, -1, 1'b1, 1'b1, 4'h0);

    // Short line while locked.
    drive_frame(V_TOTAL, V_ACTIVE, 5, -1, -1, 1'b0, 1'b0, 4'h1);

    // Overlong de during acquisition resets the good-frame count.
    drive_frame(V_TOTAL, V_ACTIVE, -1, 3, -1, 1'b0, 1'b0, 4'h3);
    drive_frame(V_TOTAL, V_ACTIVE, -1, -1, -1, 1'b0, 1'b0, 4'h3);
    drive_frame(V_TOTAL, V_ACTIVE, -1, -1, -1, 1'b0, 1'b1, 4'h3);

    // Frame one line short: caught at the following vs_rise.
    drive_frame(V_TOTAL - 1, V_ACTIVE, -1, -1, -1, 1'b1, 1'b1, 4'h3);
    drive_frame(V_TOTAL, V_ACTIVE, -1, -1, -1, 1'b1, 1'b0, 4'h7);

    drive_frame(V_TOTAL, V_ACTIVE, -1, -1, -1, 1'b0, 1'b0, 4'h7);
    drive_frame(V_TOTAL, V_ACTIVE, -1, -1, -1, 1'b0, 1'b0, 4'h7);
    drive_frame(V_TOTAL, V_ACTIVE, -1, -1, -1, 1'b0, 1'b1, 4'h7);

    // One active line missing while locked.
    drive_frame(V_TOTAL, V_ACTIVE - 1, -1, -1, -1, 1'b1, 1'b0, 4'hF);

    drive_frame(V_TOTAL, V_ACTIVE, -1, -1, -1, 1'b0, 1'b0, 4'hF);
    drive_frame(V_TOTAL, V_ACTIVE, -1, -1, -1, 1'b0, 1'b0, 4'hF);
    drive_frame(V_TOTAL, V_ACTIVE, -1, -1, -1, 1'b0, 1'b1, 4'hF);

    // Reset mid-frame while locked, then reacquire from scratch.
    drive_frame(V_TOTAL, V_ACTIVE, -1, -1, 10, 1'b1, 1'b1, 4'hF);
    drive_frame(V_TOTAL, V_ACTIVE, -1, -1, -1, 1'b0, 1'b0, 4'h0);
    drive_frame(V_TOTAL, V_ACTIVE, -1, -1, -1, 1'b0, 1'b0, 4'h0);
    drive_frame(V_TOTAL, V_ACTIVE, -1, -1, -1, 1'b0, 1'b1, 4'h0);
    drive_frame(V_TOTAL, V_ACTIVE, -1, -1, -1, 1'b1, 1'b1, 4'h0);

    @(posedge clk_pix);
    #1 check("final_drained", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
